// File: rtl/bus_arbiter2.sv
// Two-requester round-robin bus arbiter with a registered output slot.
// Ports: clk, reset (sync, active-high); REQ0/D0, REQ1/D1 requesters;
// READY consumer accept; S mux select; ACK0/ACK1 capture pulses;
// Y registered data; VALID marks Y as not yet consumed.
module bus_arbiter2 #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         REQ0,
    input  logic [n-1:0] D0,
    input  logic         REQ1,
    input  logic [n-1:0] D1,
    input  logic         READY,
    output logic         S,
    output logic         ACK0,
    output logic         ACK1,
    output logic [n-1:0] Y,
    output logic         VALID
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state;
    logic   last;
    logic   slot_free;

    assign S         = (state == GRANT1);
    assign slot_free = !VALID || READY;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
            Y     <= '0;
            VALID <= 1'b0;
            ACK0  <= 1'b0;
            ACK1  <= 1'b0;
        end else begin
            ACK0 <= 1'b0;
            ACK1 <= 1'b0;
            // Consumer drains the slot; a capture below overrides this
            // so a simultaneous drain and refill leaves no bubble.
            if (VALID && READY)
                VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (REQ0 && REQ1)
                        state <= last ? GRANT0 : GRANT1;
                    else if (REQ0)
                        state <= GRANT0;
                    else if (REQ1)
                        state <= GRANT1;
                end
                GRANT0: begin
                    if (!REQ0) begin
                        state <= IDLE;
                    end else if (slot_free) begin
                        Y     <= D0;
                        VALID <= 1'b1;
                        ACK0  <= 1'b1;
                        last  <= 1'b0;
                        state <= IDLE;
                    end
                end
                GRANT1: begin
                    if (!REQ1) begin
                        state <= IDLE;
                    end else if (slot_free) begin
                        Y     <= D1;
                        VALID <= 1'b1;
                        ACK1  <= 1'b1;
                        last  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Self-checking bench for bus_arbiter2: cycle model plus directed tests.
// Ports: none (top-level bench).
module tb_bus_arbiter2;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         REQ0, REQ1, READY;
    logic [N-1:0] D0, D1;
    logic         S, ACK0, ACK1, VALID;
    logic [N-1:0] Y;

    int tests = 0;
    int fails = 0;
    bit en = 1'b0;

    bus_arbiter2 #(.n(N)) dut (
        .clk(clk), .reset(reset),
        .REQ0(REQ0), .D0(D0),
        .REQ1(REQ1), .D1(D1),
        .READY(READY),
        .S(S), .ACK0(ACK0), .ACK1(ACK1),
        .Y(Y), .VALID(VALID)
    );

    always #5 clk = ~clk;

    // Model: who currently holds the grant (-1 = nobody), who was served
    // last, and the contents of the single output slot.
    int           owner = -1;
    int           served_last = 1;
    logic [N-1:0] m_y = '0;
    logic         m_valid = 1'b0;
    logic         m_ack0 = 1'b0;
    logic         m_ack1 = 1'b0;

    always begin
        @(posedge clk);
        if (reset === 1'b1) begin
            owner = -1;
            served_last = 1;
            m_y = '0;
            m_valid = 1'b0;
            m_ack0 = 1'b0;
            m_ack1 = 1'b0;
        end else begin
            bit room;
            bit still;
            room = !m_valid || READY;
            m_ack0 = 1'b0;
            m_ack1 = 1'b0;
            if (m_valid && READY)
                m_valid = 1'b0;
            if (owner < 0) begin
                if (REQ0 && REQ1)
                    owner = 1 - served_last;
                else if (REQ0)
                    owner = 0;
                else if (REQ1)
                    owner = 1;
            end else begin
                still = (owner == 0) ? REQ0 : REQ1;
                if (!still) begin
                    owner = -1;
                end else if (room) begin
                    m_y = (owner == 0) ? D0 : D1;
                    m_valid = 1'b1;
                    if (owner == 0) m_ack0 = 1'b1;
                    else m_ack1 = 1'b1;
                    served_last = owner;
                    owner = -1;
                end
            end
        end
        #1;
        if (en) begin
            logic [N+3:0] act, exp;
            act = {S, ACK0, ACK1, VALID, Y};
            exp = {(owner == 1), m_ack0, m_ack1, m_valid, m_y};
            tests++;
            if (act !== exp || (ACK0 && ACK1)) begin
                fails++;
                $display("FAIL model t=%0t got S/A0/A1/V/Y=%h want %h",
                         $time, act, exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(string name, logic [N-1:0] act, logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        REQ0 = 1'b0; REQ1 = 1'b0; READY = 1'b0;
        D0 = '0; D1 = '0;
        tick();
        en = 1'b1;
        tick();
        chk("rst_y", Y, 32'h0);
        chk("rst_valid", {31'b0, VALID}, 32'h0);
        chk("rst_s", {31'b0, S}, 32'h0);
        chk("rst_ack", {30'b0, ACK0, ACK1}, 32'h0);

        // Single request right after reset
        reset = 1'b0;
        REQ0 = 1'b1; D0 = 32'h80000000; READY = 1'b1;
        tick();
        chk("r_e1_s", {31'b0, S}, 32'h0);
        chk("r_e1_ack0", {31'b0, ACK0}, 32'h0);
        tick();
        chk("r_e2_y", Y, 32'h80000000);
        chk("r_e2_valid", {31'b0, VALID}, 32'h1);
        chk("r_e2_ack0", {31'b0, ACK0}, 32'h1);
        REQ0 = 1'b0;
        tick();
        chk("r_e3_ack0", {31'b0, ACK0}, 32'h0);
        chk("r_e3_valid", {31'b0, VALID}, 32'h0);

        // Tie from fresh reset: 0, 1, 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        REQ0 = 1'b1; REQ1 = 1'b1;
        D0 = 32'h80000000; D1 = 32'h00000001; READY = 1'b1;
        tick();
        chk("t_e1_s", {31'b0, S}, 32'h0);
        tick();
        chk("t_e2_y", Y, 32'h80000000);
        chk("t_e2_ack", {30'b0, ACK0, ACK1}, 32'h2);
        tick();
        chk("t_e3_s", {31'b0, S}, 32'h1);
        tick();
        chk("t_e4_y", Y, 32'h00000001);
        chk("t_e4_ack", {30'b0, ACK0, ACK1}, 32'h1);
        tick();
        chk("t_e5_s", {31'b0, S}, 32'h0);
        tick();
        chk("t_e6_y", Y, 32'h80000000);
        chk("t_e6_ack", {30'b0, ACK0, ACK1}, 32'h2);

        // Backpressure on requester 1
        REQ0 = 1'b0; REQ1 = 1'b1; READY = 1'b0;
        tick();
        chk("b_e1_s", {31'b0, S}, 32'h1);
        chk("b_e1_v", {31'b0, VALID}, 32'h1);
        tick();
        chk("b_e2_s", {31'b0, S}, 32'h1);
        chk("b_e2_ack1", {31'b0, ACK1}, 32'h0);
        chk("b_e2_y", Y, 32'h80000000);
        READY = 1'b1;
        tick();
        chk("b_e3_y", Y, 32'h00000001);
        chk("b_e3_v", {31'b0, VALID}, 32'h1);
        chk("b_e3_ack1", {31'b0, ACK1}, 32'h1);
        REQ1 = 1'b0; D1 = 32'h5A5A5A5A;
        tick();
        chk("b_e4_v", {31'b0, VALID}, 32'h0);

        // Withdraw while granted
        REQ0 = 1'b1; D0 = 32'hAAAA5555; READY = 1'b0;
        tick();
        chk("w_e1_s", {31'b0, S}, 32'h0);
        REQ0 = 1'b0;
        tick();
        chk("w_e2_ack", {30'b0, ACK0, ACK1}, 32'h0);
        chk("w_e2_y", Y, 32'h00000001);
        chk("w_e2_v", {31'b0, VALID}, 32'h0);
        tick();

        // Reset in the middle of a GRANT1 with a full slot
        REQ0 = 1'b1; D0 = 32'h12345678;
        tick();
        tick();
        chk("m_cap_y", Y, 32'h12345678);
        REQ0 = 1'b0; REQ1 = 1'b1; D1 = 32'hDEADBEEF;
        tick();
        chk("m_g1_s", {31'b0, S}, 32'h1);
        chk("m_g1_v", {31'b0, VALID}, 32'h1);
        reset = 1'b1;
        tick();
        chk("m_rst_y", Y, 32'h0);
        chk("m_rst_v", {31'b0, VALID}, 32'h0);
        chk("m_rst_s", {31'b0, S}, 32'h0);
        chk("m_rst_ack", {30'b0, ACK0, ACK1}, 32'h0);
        reset = 1'b0;
        REQ0 = 1'b1; REQ1 = 1'b1; READY = 1'b1;
        tick();
        chk("m_tie_s", {31'b0, S}, 32'h0);
        tick();
        chk("m_tie_ack", {30'b0, ACK0, ACK1}, 32'h2);
        chk("m_tie_y", Y, 32'h12345678);
        REQ0 = 1'b0; REQ1 = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
